mem_port_arbiter: RTL and testbench

Parametrised N-channel arbiter that lets several requesters share one memory unit through the codebase's standard memory handshake: valid, rw, addr, data_in, byte_half_word, is_load_unsigned in; ready, out_of_range, data_out back. It sits between the core's program/data access paths (and EEI loaders) and a single `memory` instance. It generalises the fixed two-memory arrangement of the single-cycle core to NUM_CH channels with selectable round-robin or fixed priority. It adds a response timeout that the plain memory path lacks.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory unit among NUM_CH requesters using the valid/ready memory handshake.
// Supports round-robin or fixed priority, a one-cycle GAP after each transaction, and an optional response timeout.
module mem_port_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_valid,
    input  logic [NUM_CH-1:0]          ch_rw,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data_in,
    input  logic [2*NUM_CH-1:0]        ch_byte_half_word,
    input  logic [NUM_CH-1:0]          ch_is_load_unsigned,
    output logic [NUM_CH-1:0]          ch_ready,
    output logic [NUM_CH-1:0]          ch_out_of_range,
    output logic [DATA_W-1:0]          ch_data_out,
    output logic                       mem_valid,
    output logic                       mem_rw,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data_in,
    output logic [1:0]                 mem_byte_half_word,
    output logic                       mem_is_load_unsigned,
    input  logic                       mem_ready,
    input  logic                       mem_out_of_range,
    input  logic [DATA_W-1:0]          mem_data_out,
    output logic                       busy,
    output logic [$clog2(NUM_CH)-1:0]  grant_id,
    output logic                       timeout_err
);

    localparam int GW = $clog2(NUM_CH);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [GW-1:0]   r_grantId;
    logic [GW-1:0]   r_rrPtr;
    logic [TW-1:0]   r_timer;
    logic            r_timeoutErr;

    logic [GW-1:0]   w_winner;
    logic            w_anyValid;
    logic            w_resp;
    logic            w_timeout;
    logic            w_done;

    // Winner search: first pass covers channels at or above the RR pointer, second pass wraps to the bottom.
    always_comb begin
        w_winner   = '0;
        w_anyValid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_anyValid && ch_valid[k] && (RR_MODE == 0 || GW'(k) >= r_rrPtr)) begin
                w_winner   = GW'(k);
                w_anyValid = 1'b1;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_anyValid && ch_valid[k]) begin
                w_winner   = GW'(k);
                w_anyValid = 1'b1;
            end
        end
    end

    assign w_resp = mem_ready | mem_out_of_range;

    // Next state plus the combinational request mux and response pulses; pulses are suppressed while rst is high.
    always_comb begin
        w_nextState          = r_state;
        w_timeout            = 1'b0;
        w_done               = 1'b0;
        mem_valid            = 1'b0;
        mem_rw               = 1'b0;
        mem_addr             = '0;
        mem_data_in          = '0;
        mem_byte_half_word   = 2'b00;
        mem_is_load_unsigned = 1'b0;
        ch_ready             = '0;
        ch_out_of_range      = '0;
        ch_data_out          = '0;
        case (r_state)
            IDLE: begin
                if (w_anyValid) begin
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                mem_valid            = 1'b1;
                mem_rw               = ch_rw[r_grantId];
                mem_addr             = ch_addr[int'(r_grantId) * ADDR_W +: ADDR_W];
                mem_data_in          = ch_data_in[int'(r_grantId) * DATA_W +: DATA_W];
                mem_byte_half_word   = ch_byte_half_word[int'(r_grantId) * 2 +: 2];
                mem_is_load_unsigned = ch_is_load_unsigned[r_grantId];
                w_timeout            = (TIMEOUT != 0) && !w_resp && (r_timer == TW'(TIMEOUT));
                if (w_resp || w_timeout) begin
                    w_done      = 1'b1;
                    w_nextState = GAP;
                end
                if (!rst) begin
                    if (mem_ready) begin
                        ch_ready[r_grantId] = 1'b1;
                        ch_data_out         = mem_data_out;
                    end
                    if (mem_out_of_range || w_timeout) begin
                        ch_out_of_range[r_grantId] = 1'b1;
                    end
                end
            end
            GAP: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register together with the grant, RR pointer, timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grantId    <= '0;
            r_rrPtr      <= '0;
            r_timer      <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_anyValid) begin
                r_grantId <= w_winner;
                r_timer   <= '0;
            end
            if (r_state == BUSY) begin
                if (w_done) begin
                    if (RR_MODE != 0) begin
                        r_rrPtr <= (r_grantId == GW'(NUM_CH - 1)) ? '0 : r_grantId + 1'b1;
                    end
                    if (w_timeout) begin
                        r_timeoutErr <= 1'b1;
                    end
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign grant_id    = r_grantId;
    assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin instance checked cycle by cycle against a transaction-level model,
// plus a fixed-priority instance with an always-ready memory used for the starvation scenario.
module tb_mem_port_arbiter;

    localparam int NCH        = 4;
    localparam int TIMEOUT_RR = 4;

    logic             clk;
    logic             rst;
    logic [NCH-1:0]   chValid;
    logic [NCH-1:0]   chRw;
    logic [NCH*32-1:0] chAddr;
    logic [NCH*32-1:0] chDataIn;
    logic [2*NCH-1:0] chBhw;
    logic [NCH-1:0]   chUns;

    logic [NCH-1:0]   chReady, chOor;
    logic [31:0]      chDataOut;
    logic             memValid, memRw, memUns, memReady, memOor, busyO, timeoutErr;
    logic [31:0]      memAddr, memDataIn, memDataOut;
    logic [1:0]       memBhw, grantId;

    logic [NCH-1:0]   fxChReady, fxChOor;
    logic [31:0]      fxChDataOut, fxMemAddr, fxMemDataIn, fxMemDataOut;
    logic             fxMemValid, fxMemRw, fxMemUns, fxMemOor, fxBusy, fxTimeoutErr;
    logic [1:0]       fxMemBhw, fxGrantId;

    assign fxMemDataOut = 32'h1234_5678;
    assign fxMemOor     = 1'b0;

    mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT(TIMEOUT_RR)) dutRr (
        .clk(clk), .rst(rst), .ch_valid(chValid), .ch_rw(chRw), .ch_addr(chAddr), .ch_data_in(chDataIn),
        .ch_byte_half_word(chBhw), .ch_is_load_unsigned(chUns), .ch_ready(chReady), .ch_out_of_range(chOor),
        .ch_data_out(chDataOut), .mem_valid(memValid), .mem_rw(memRw), .mem_addr(memAddr),
        .mem_data_in(memDataIn), .mem_byte_half_word(memBhw), .mem_is_load_unsigned(memUns),
        .mem_ready(memReady), .mem_out_of_range(memOor), .mem_data_out(memDataOut),
        .busy(busyO), .grant_id(grantId), .timeout_err(timeoutErr)
    );

    mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT(0)) dutFx (
        .clk(clk), .rst(rst), .ch_valid(chValid), .ch_rw(chRw), .ch_addr(chAddr), .ch_data_in(chDataIn),
        .ch_byte_half_word(chBhw), .ch_is_load_unsigned(chUns), .ch_ready(fxChReady), .ch_out_of_range(fxChOor),
        .ch_data_out(fxChDataOut), .mem_valid(fxMemValid), .mem_rw(fxMemRw), .mem_addr(fxMemAddr),
        .mem_data_in(fxMemDataIn), .mem_byte_half_word(fxMemBhw), .mem_is_load_unsigned(fxMemUns),
        .mem_ready(fxMemValid), .mem_out_of_range(fxMemOor), .mem_data_out(fxMemDataOut),
        .busy(fxBusy), .grant_id(fxGrantId), .timeout_err(fxTimeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester and memory state kept by the bench.
    logic [NCH-1:0] reqValidV;
    logic           reqRw  [NCH];
    logic [31:0]    reqAddr[NCH];
    logic [31:0]    reqData[NCH];
    logic [1:0]     reqBhw [NCH];
    logic           reqUns [NCH];
    logic [31:0]    memArr [logic [31:0]];

    // Transaction-level model of the arbiter.
    bit mdlActive, mdlTimeoutErr, autoRefill;
    int mdlOwner, mdlBusyCnt, mdlLatency, mdlPtr, mdlFreeCycle;
    int cycleNo, fixedLat, heldMode, dropCh, dropDelay;
    int nChecks, nPass, nFail;

    // Observed tallies for the directed scenarios.
    int obsValidCnt, obsReadyCnt, obsOorCnt, obsBothCnt, firstValidCycle, lastOorCycle;
    logic [31:0] lastReadyData;
    bit prevMemValid;
    int readyLog[$];
    int readyCycles[$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycleNo);
        end
    endtask

    function automatic bit isOor(input logic [31:0] a);
        return a >= 32'hFFFF_0000;
    endfunction

    function automatic bit bothResp(input logic [31:0] a);
        logic [31:0] t;
        t = a;
        return isOor(t) && t[2];
    endfunction

    function automatic logic [31:0] memRead(input logic [31:0] a);
        return memArr.exists(a) ? memArr[a] : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic int pickWinner(input logic [NCH-1:0] v, input int ptr);
        for (int k = 0; k < NCH; k++) begin
            if (v[(ptr + k) % NCH]) return (ptr + k) % NCH;
        end
        return -1;
    endfunction

    task automatic setRequest(input int i, input logic rw, input logic [31:0] a, input logic [31:0] d);
        reqValidV[i] = 1'b1;
        reqRw[i]     = rw;
        reqAddr[i]   = a;
        reqData[i]   = d;
        reqBhw[i]    = 2'(i % 3);
        reqUns[i]    = 1'(i);
    endtask

    task automatic newRequest(input int i);
        reqValidV[i] = 1'b1;
        reqRw[i]     = 1'($urandom_range(0, 1));
        reqAddr[i]   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | ($urandom & 32'hFC)) : ($urandom & 32'h0000_0FFC);
        reqData[i]   = $urandom;
        reqBhw[i]    = 2'($urandom_range(0, 2));
        reqUns[i]    = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NCH; i++) begin
            chAddr[i*32 +: 32]   = reqAddr[i];
            chDataIn[i*32 +: 32] = reqData[i];
            chBhw[i*2 +: 2]      = reqBhw[i];
            chRw[i]              = reqRw[i];
            chUns[i]             = reqUns[i];
        end
        chValid = reqValidV;
    endtask

    task automatic clearTallies();
        obsValidCnt = 0; obsReadyCnt = 0; obsOorCnt = 0; obsBothCnt = 0;
        firstValidCycle = -1; lastOorCycle = -1; lastReadyData = '0;
        readyLog.delete(); readyCycles.delete();
    endtask

    // Compare this cycle's DUT outputs with the model, then advance the model.
    task automatic checkCycle();
        logic [31:0] a;
        logic [NCH-1:0] oh;
        bit resp, to, expReady, expOor;
        if (mdlActive) begin
            a        = reqAddr[mdlOwner];
            oh       = NCH'(1) << mdlOwner;
            resp     = (mdlBusyCnt == mdlLatency);
            to       = !resp && (mdlBusyCnt == TIMEOUT_RR);
            expReady = resp && (!isOor(a) || bothResp(a));
            expOor   = (resp && isOor(a)) || to;
            checkOutput("mem_valid", memValid, 1);
            checkOutput("busy", busyO, 1);
            checkOutput("grant_id", grantId, mdlOwner);
            checkOutput("mem_addr", memAddr, a);
            checkOutput("mem_fields", {memRw, memDataIn, memBhw, memUns},
                        {reqRw[mdlOwner], reqData[mdlOwner], reqBhw[mdlOwner], reqUns[mdlOwner]});
            checkOutput("ch_ready", chReady, expReady ? oh : '0);
            checkOutput("ch_out_of_range", chOor, expOor ? oh : '0);
            checkOutput("ch_data_out", chDataOut, expReady ? memRead(a) : 32'h0);
            checkOutput("timeout_err", timeoutErr, mdlTimeoutErr);
            if (resp || to) begin
                if (expReady && reqRw[mdlOwner] && !isOor(a)) memArr[a] = reqData[mdlOwner];
                mdlActive    = 1'b0;
                mdlFreeCycle = cycleNo + 2;
                mdlPtr       = (mdlOwner + 1) % NCH;
                if (to) mdlTimeoutErr = 1'b1;
                if (heldMode >= 0) begin
                    dropCh    = mdlOwner;
                    dropDelay = (heldMode == 2) ? $urandom_range(0, 1) : heldMode;
                end
            end else begin
                mdlBusyCnt++;
            end
        end else begin
            checkOutput("mem_valid", memValid, 0);
            checkOutput("busy", busyO, cycleNo < mdlFreeCycle);
            checkOutput("ch_ready", chReady, 0);
            checkOutput("ch_out_of_range", chOor, 0);
            checkOutput("ch_data_out", chDataOut, 0);
            checkOutput("timeout_err", timeoutErr, mdlTimeoutErr);
            if (cycleNo >= mdlFreeCycle && reqValidV != '0) begin
                mdlOwner   = pickWinner(reqValidV, mdlPtr);
                mdlActive  = 1'b1;
                mdlBusyCnt = 0;
                mdlLatency = (fixedLat >= 0) ? fixedLat : $urandom_range(0, 5);
            end
        end
    endtask

    task automatic stepCycle();
        logic [31:0] a;
        @(posedge clk);
        #1;
        cycleNo++;
        rst = 1'b0;
        if (dropCh >= 0) begin
            if (dropDelay == 0) begin
                reqValidV[dropCh] = 1'b0;
                dropCh = -1;
            end else begin
                dropDelay--;
            end
        end
        if (autoRefill) begin
            for (int i = 0; i < NCH; i++) begin
                if (!reqValidV[i] && $urandom_range(0, 3) == 0) newRequest(i);
            end
        end
        applyStimulus();
        memReady   = 1'b0;
        memOor     = 1'b0;
        memDataOut = $urandom;
        if (mdlActive && mdlBusyCnt == mdlLatency) begin
            a = reqAddr[mdlOwner];
            if (isOor(a)) begin
                memOor   = 1'b1;
                memReady = bothResp(a);
            end else begin
                memReady = 1'b1;
            end
            if (memReady) memDataOut = memRead(a);
        end
        #4;
        checkCycle();
        obsValidCnt += int'(memValid);
        if (memValid && !prevMemValid && firstValidCycle < 0) firstValidCycle = cycleNo;
        prevMemValid = memValid;
        if (chReady != '0) begin
            obsReadyCnt++;
            lastReadyData = chDataOut;
            readyLog.push_back(int'(grantId));
            readyCycles.push_back(cycleNo);
        end
        if (chOor != '0) begin
            obsOorCnt++;
            lastOorCycle = cycleNo;
        end
        if ((chReady & chOor) != '0) obsBothCnt++;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        cycleNo++;
        rst      = 1'b1;
        memReady = 1'b0;
        memOor   = 1'b0;
        #4;
        mdlActive     = 1'b0;
        mdlPtr        = 0;
        mdlTimeoutErr = 1'b0;
        mdlFreeCycle  = cycleNo + 1;
        dropCh        = -1;
        prevMemValid  = 1'b0;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int fxServed;
        nChecks = 0; nPass = 0; nFail = 0; cycleNo = 0;
        rst = 1'b1; memReady = 1'b0; memOor = 1'b0; memDataOut = '0;
        reqValidV = '0; autoRefill = 1'b0; fixedLat = 0; heldMode = 0; dropCh = -1; dropDelay = 0;
        mdlActive = 1'b0; mdlOwner = 0; mdlBusyCnt = 0; mdlLatency = 0; mdlPtr = 0; mdlFreeCycle = 0;
        mdlTimeoutErr = 1'b0; prevMemValid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            reqRw[i] = 1'b0; reqAddr[i] = '0; reqData[i] = '0; reqBhw[i] = 2'b00; reqUns[i] = 1'b0;
        end
        applyStimulus();
        clearTallies();

        // Reset state.
        applyReset();
        applyReset();
        stepCycle();
        checkOutput("rst_grant_id", grantId, 0);
        checkOutput("rst_fx_outputs", {fxMemValid, fxBusy, fxTimeoutErr, fxChReady, fxChOor}, 0);

        // Single read with two wait cycles.
        clearTallies();
        memArr[32'h10] = 32'hDEAD_BEEF;
        fixedLat = 2; heldMode = 0;
        setRequest(0, 1'b0, 32'h10, 32'h0);
        runCycles(8);
        checkOutput("read_valid_cycles", obsValidCnt, 3);
        checkOutput("read_ready_pulses", obsReadyCnt, 1);
        checkOutput("read_data", lastReadyData, 32'hDEAD_BEEF);

        // Requester holds valid one cycle past ready.
        clearTallies();
        fixedLat = 1; heldMode = 1;
        setRequest(1, 1'b0, 32'h20, 32'h0);
        runCycles(8);
        checkOutput("held_valid_cycles", obsValidCnt, 2);
        checkOutput("held_ready_pulses", obsReadyCnt, 1);

        // Out-of-range write, then a response with both ready and out_of_range.
        clearTallies();
        heldMode = 0;
        setRequest(0, 1'b1, 32'hFFFF_FFF0, 32'hCAFE_F00D);
        runCycles(6);
        checkOutput("oor_pulses", obsOorCnt, 1);
        checkOutput("oor_ready_pulses", obsReadyCnt, 0);
        checkOutput("oor_timeout_err", timeoutErr, 0);
        clearTallies();
        setRequest(3, 1'b0, 32'hFFFF_FFF4, 32'h0);
        runCycles(6);
        checkOutput("both_pulses", obsBothCnt, 1);

        // Timeout with a memory that never answers.
        clearTallies();
        fixedLat = 100;
        setRequest(2, 1'b0, 32'h30, 32'h0);
        runCycles(10);
        checkOutput("timeout_pulse_busy_cycle", lastOorCycle - firstValidCycle + 1, TIMEOUT_RR + 1);
        checkOutput("timeout_valid_cycles", obsValidCnt, TIMEOUT_RR + 1);
        checkOutput("timeout_err_set", timeoutErr, 1);

        // Reset in the middle of a transaction, then a grant that reveals the RR pointer.
        setRequest(2, 1'b0, 32'h40, 32'h0);
        runCycles(3);
        checkOutput("pre_reset_busy", memValid, 1);
        applyReset();
        clearTallies();
        setRequest(1, 1'b0, 32'h44, 32'h0);
        setRequest(3, 1'b0, 32'h48, 32'h0);
        fixedLat = 0;
        stepCycle();
        checkOutput("post_reset_pulses", {chReady, chOor, memValid}, 0);
        runCycles(14);
        checkOutput("post_reset_served", obsReadyCnt, 3);
        if (readyLog.size() > 0) checkOutput("post_reset_first_grant", readyLog[0], 1);

        // Fairness: all channels valid continuously with a zero-wait memory.
        applyReset();
        clearTallies();
        fixedLat = 0; heldMode = -1; fxServed = 0;
        for (int i = 0; i < NCH; i++) setRequest(i, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
        for (int c = 0; c < 16; c++) begin
            stepCycle();
            checkOutput("fx_no_oor", fxChOor, 0);
            if (fxMemValid) begin
                fxServed++;
                checkOutput("fx_grant", fxGrantId, 0);
                checkOutput("fx_fields", {fxMemRw, fxMemAddr, fxMemDataIn, fxMemBhw, fxMemUns, fxBusy},
                            {reqRw[0], reqAddr[0], reqData[0], reqBhw[0], reqUns[0], 1'b1});
                checkOutput("fx_ready", fxChReady, 4'b0001);
                checkOutput("fx_data", fxChDataOut, 32'h1234_5678);
            end else begin
                checkOutput("fx_ready_idle", fxChReady, 0);
            end
        end
        checkOutput("fx_served", fxServed, 5);
        checkOutput("fx_timeout_err", fxTimeoutErr, 0);
        checkOutput("rr_grant_count", readyLog.size(), 5);
        if (readyLog.size() >= 5) begin
            for (int k = 0; k < 5; k++) checkOutput("rr_grant_order", readyLog[k], k % NCH);
            for (int k = 0; k < 4; k++) checkOutput("rr_grant_spacing", readyCycles[k+1] - readyCycles[k], 3);
        end
        reqValidV = '0;
        runCycles(4);

        // Randomized traffic: random latencies, held valid, out-of-range and timeouts.
        heldMode = 2; fixedLat = -1; autoRefill = 1'b1;
        runCycles(400);
        autoRefill = 1'b0;
        runCycles(40);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
